// File: rtl/peripheral_core_pkg.sv
// Shared definitions for the peripheral counter core.
// Contents:
//   COUNT_W, FIFO_DATA_W, FIFO_CNT_W : datapath widths.
//   LT_1K_THRESHOLD                  : default compare value for the less-than flag.
//   cfg_t / CFG_RESET                : config register layout and its reset value.
//   is_wrap()                        : true when one count step in the given direction wraps.
package peripheral_core_pkg;

    localparam int COUNT_W     = 32;
    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_CNT_W  = 8;
    localparam int unsigned LT_1K_THRESHOLD = 1000;

    typedef struct packed {
        logic en;
        logic dir;
        logic ire;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{en: 1'b0, dir: 1'b1, ire: 1'b0};

    // Up wraps from all-ones, down wraps from zero.
    function automatic logic is_wrap(input logic dir, input logic [COUNT_W-1:0] value);
        return dir ? (&value) : ~(|value);
    endfunction

endpackage

// File: rtl/peripheral_counter_core_if.sv
// Register-side bundle between the native register interface and the core.
// master : drives write strobes and write data, reads back values/status.
// slave  : the core; consumes strobes, produces read-back and irq_out.
// fifo_overflow exists only when PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN is defined.
interface peripheral_counter_core_if;
    import peripheral_core_pkg::*;

    logic                   count_we;
    logic                   config_we;
    logic                   fifo_we;
    logic                   fifo_re;
    logic [COUNT_W-1:0]     count_in;
    logic                   en_in;
    logic                   dir_in;
    logic                   ire_in;
    logic [FIFO_DATA_W-1:0] fifo_data_in;

    logic [COUNT_W-1:0]     count_out;
    logic                   en_out;
    logic                   dir_out;
    logic                   ire_out;
    logic                   lt_1k_out;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [FIFO_CNT_W-1:0]  fifo_word_count;
    logic [FIFO_DATA_W-1:0] fifo_data_out;
    logic                   irq_out;
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
    logic                   fifo_overflow;
`endif

    modport master (
        output count_we, config_we, fifo_we, fifo_re,
        output count_in, en_in, dir_in, ire_in, fifo_data_in,
        input  count_out, en_out, dir_out, ire_out, lt_1k_out,
        input  fifo_empty, fifo_full, fifo_word_count, fifo_data_out, irq_out
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
        , input fifo_overflow
`endif
    );

    modport slave (
        input  count_we, config_we, fifo_we, fifo_re,
        input  count_in, en_in, dir_in, ire_in, fifo_data_in,
        output count_out, en_out, dir_out, ire_out, lt_1k_out,
        output fifo_empty, fifo_full, fifo_word_count, fifo_data_out, irq_out
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
        , output fifo_overflow
`endif
    );

endinterface

// File: rtl/peripheral_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// Ports:
//   clk, reset          : clock, synchronous active-high reset.
//   push, push_data     : write request and data; dropped when full unless popping.
//   pop                 : read request; ignored when empty.
//   empty, full         : occupancy flags.
//   word_count          : entries held, 0..FIFO_DEPTH.
//   head_data           : oldest entry straight from storage, zero while empty.
module peripheral_sync_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  word_count,
    output logic [DATA_W-1:0] head_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign word_count = count_q;
    assign head_data  = empty ? '0 : mem_q[rd_ptr_q];

    // A push while full is only accepted together with a pop: the write then
    // lands in the slot the pop frees. A pop on empty is ignored, so a
    // push+pop on empty degenerates to a plain push.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; head_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/peripheral_counter_core.sv
// Peripheral core datapath behind the native register interface.
// Holds a 32-bit up/down counter with en/dir/ire config, a sticky wrap flag
// feeding a registered level interrupt, a less-than-threshold status flag and
// an 8-bit first-word-fall-through FIFO.
// Ports:
//   clk   : core clock.
//   reset : synchronous active-high reset; overrides any same-cycle strobe.
//   bus   : slave side of peripheral_counter_core_if (strobes, write data,
//           read-back, status and irq_out).
// Optional: define PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN to add the sticky
// fifo_overflow flag, which also contributes to irq_out when ire is set.
module peripheral_counter_core
    import peripheral_core_pkg::*;
#(
    parameter int                 FIFO_DEPTH   = 16,
    parameter logic [COUNT_W-1:0] LT_THRESHOLD = COUNT_W'(LT_1K_THRESHOLD)
) (
    input  logic                      clk,
    input  logic                      reset,
    peripheral_counter_core_if.slave  bus
);

    logic [COUNT_W-1:0]     count_q, count_d;
    cfg_t                   cfg_q, cfg_d;
    logic                   wrap_q, wrap_d;
    logic                   irq_q, irq_d;
    logic                   wrap_event;
    logic                   fifo_empty_w;
    logic                   fifo_full_w;
    logic [FIFO_CNT_W-1:0]  fifo_count_w;
    logic [FIFO_DATA_W-1:0] fifo_head_w;
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
    logic                   overflow_q, overflow_d;
`endif

    // A load beats a step; a step always uses the config currently held, so a
    // config write in the same cycle only affects the following cycles. The
    // wrap flag is sticky but any register write clears it, and the clear
    // beats a wrap occurring on the same edge. irq is a registered copy of
    // ire & flag, so it trails the flag by one cycle.
    always_comb begin
        count_d    = count_q;
        wrap_event = 1'b0;
        if (bus.count_we) begin
            count_d = bus.count_in;
        end else if (cfg_q.en) begin
            wrap_event = is_wrap(cfg_q.dir, count_q);
            count_d    = cfg_q.dir ? (count_q + COUNT_W'(1)) : (count_q - COUNT_W'(1));
        end

        cfg_d = cfg_q;
        if (bus.config_we) begin
            cfg_d = '{en: bus.en_in, dir: bus.dir_in, ire: bus.ire_in};
        end

        wrap_d = (bus.count_we || bus.config_we) ? 1'b0 : (wrap_q || wrap_event);

`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
        overflow_d = bus.config_we ? 1'b0
                   : (overflow_q || (bus.fifo_we && fifo_full_w && !bus.fifo_re));
        irq_d      = cfg_q.ire && (wrap_q || overflow_q);
`else
        irq_d      = cfg_q.ire && wrap_q;
`endif
    end

    // Counter, config, wrap flag and interrupt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            cfg_q   <= CFG_RESET;
            wrap_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cfg_q   <= cfg_d;
            wrap_q  <= wrap_d;
            irq_q   <= irq_d;
        end
    end

`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
    // Sticky record of a push dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.fifo_overflow = overflow_q;
`endif

    peripheral_sync_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (FIFO_DATA_W),
        .CNT_W      (FIFO_CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (bus.fifo_we),
        .pop        (bus.fifo_re),
        .push_data  (bus.fifo_data_in),
        .empty      (fifo_empty_w),
        .full       (fifo_full_w),
        .word_count (fifo_count_w),
        .head_data  (fifo_head_w)
    );

    assign bus.count_out       = count_q;
    assign bus.en_out          = cfg_q.en;
    assign bus.dir_out         = cfg_q.dir;
    assign bus.ire_out         = cfg_q.ire;
    assign bus.lt_1k_out       = (count_q < LT_THRESHOLD);
    assign bus.irq_out         = irq_q;
    assign bus.fifo_empty      = fifo_empty_w;
    assign bus.fifo_full       = fifo_full_w;
    assign bus.fifo_word_count = fifo_count_w;
    assign bus.fifo_data_out   = fifo_head_w;

endmodule

// File: tb/tb_peripheral_counter_core.sv
// Self-checking bench for peripheral_counter_core: directed scenarios followed
// by randomized traffic, all compared against a behavioural model that keeps
// the count as a plain integer and the FIFO as a queue.
module tb_peripheral_counter_core;
    import peripheral_core_pkg::*;

    localparam int    DEPTH     = 16;
    localparam longint COUNT_MAX = 64'd4294967295;
    localparam longint THRESH    = 1000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    peripheral_counter_core_if bus ();

    peripheral_counter_core #(
        .FIFO_DEPTH   (DEPTH),
        .LT_THRESHOLD (32'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state
    longint         m_count;
    bit             m_en, m_dir, m_ire, m_wrap, m_irq, m_ovf;
    byte unsigned   m_fifo[$];

    // One comparison: counts it, and on a miscompare reports tag/observed/expected.
    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic modelStep(input bit rst, input bit cwe, input bit cfgwe, input bit fwe, input bit fre,
                             input logic [31:0] cin, input bit en, input bit dir, input bit ire,
                             input logic [7:0] din);
        bit     wrapped;
        bit     was_full;
        bit     popped;
        longint nxt;
        wrapped = 1'b0;
        popped  = 1'b0;
        if (rst) begin
            m_count = 0;
            m_en = 0; m_dir = 1; m_ire = 0;
            m_wrap = 0; m_irq = 0; m_ovf = 0;
            m_fifo.delete();
            return;
        end
        m_irq = m_ire && (m_wrap || m_ovf);
        if (cwe) begin
            m_count = longint'(cin);
        end else if (m_en) begin
            nxt = m_count + (m_dir ? 1 : -1);
            if (nxt < 0) begin
                nxt = COUNT_MAX;
                wrapped = 1'b1;
            end else if (nxt > COUNT_MAX) begin
                nxt = 0;
                wrapped = 1'b1;
            end
            m_count = nxt;
        end
        m_wrap = (cwe || cfgwe) ? 1'b0 : (m_wrap || wrapped);
        if (cfgwe) begin
            m_en = en; m_dir = dir; m_ire = ire;
        end
        was_full = (m_fifo.size() == DEPTH);
        if (fre && m_fifo.size() > 0) begin
            void'(m_fifo.pop_front());
            popped = 1'b1;
        end
        if (fwe && (!was_full || popped)) begin
            m_fifo.push_back(din);
        end
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
        m_ovf = cfgwe ? 1'b0 : (m_ovf || (fwe && was_full && !fre));
`endif
    endtask

    // Compare every output against the model.
    task automatic checkOutput();
        checkValue("count_out", bus.count_out, m_count[31:0]);
        checkValue("en_out", 32'(bus.en_out), 32'(m_en));
        checkValue("dir_out", 32'(bus.dir_out), 32'(m_dir));
        checkValue("ire_out", 32'(bus.ire_out), 32'(m_ire));
        checkValue("lt_1k_out", 32'(bus.lt_1k_out), 32'(m_count < THRESH));
        checkValue("irq_out", 32'(bus.irq_out), 32'(m_irq));
        checkValue("fifo_empty", 32'(bus.fifo_empty), 32'(m_fifo.size() == 0));
        checkValue("fifo_full", 32'(bus.fifo_full), 32'(m_fifo.size() == DEPTH));
        checkValue("fifo_word_count", 32'(bus.fifo_word_count), 32'(m_fifo.size()));
        checkValue("fifo_data_out", 32'(bus.fifo_data_out),
                   (m_fifo.size() > 0) ? 32'(m_fifo[0]) : 32'd0);
`ifdef PERIPHERAL_COUNTER_CORE_FIFO_OVERFLOW_EN
        checkValue("fifo_overflow", 32'(bus.fifo_overflow), 32'(m_ovf));
`endif
    endtask

    // Drive one cycle of inputs, step the model at the edge, check at the falling edge.
    task automatic applyStimulus(input bit rst, input bit cwe, input bit cfgwe, input bit fwe, input bit fre,
                                 input logic [31:0] cin, input bit en, input bit dir, input bit ire,
                                 input logic [7:0] din);
        reset            = rst;
        bus.count_we     = cwe;
        bus.config_we    = cfgwe;
        bus.fifo_we      = fwe;
        bus.fifo_re      = fre;
        bus.count_in     = cin;
        bus.en_in        = en;
        bus.dir_in       = dir;
        bus.ire_in       = ire;
        bus.fifo_data_in = din;
        @(posedge clk);
        modelStep(rst, cwe, cfgwe, fwe, fre, cin, en, dir, ire, din);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 8'd0);
        end
    endtask

    initial begin
        logic [31:0] rnd_cin;
        reset            = 1'b1;
        bus.count_we     = 1'b0;
        bus.config_we    = 1'b0;
        bus.fifo_we      = 1'b0;
        bus.fifo_re      = 1'b0;
        bus.count_in     = '0;
        bus.en_in        = 1'b0;
        bus.dir_in       = 1'b0;
        bus.ire_in       = 1'b0;
        bus.fifo_data_in = '0;
        @(negedge clk);

        $display("[TB] reset and count-up through the 1000 threshold");
        applyStimulus(1, 0, 0, 0, 0, 32'd0, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 32'd0, 0, 0, 0, 8'd0);
        checkValue("reset_dir_const", 32'(bus.dir_out), 32'd1);
        checkValue("reset_lt_const", 32'(bus.lt_1k_out), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 32'd0, 1, 1, 0, 8'd0);
        checkValue("count_after_cfg", bus.count_out, 32'd0);
        idleCycles(1000);
        checkValue("count_at_1000", bus.count_out, 32'd1000);
        checkValue("lt_at_1000", 32'(bus.lt_1k_out), 32'd0);
        idleCycles(3);

        $display("[TB] up wrap with interrupt");
        applyStimulus(0, 1, 1, 0, 0, 32'hFFFF_FFFE, 1, 1, 1, 8'd0);
        idleCycles(2);
        checkValue("count_wrapped", bus.count_out, 32'd0);
        checkValue("irq_before", 32'(bus.irq_out), 32'd0);
        idleCycles(1);
        checkValue("irq_after_wrap", 32'(bus.irq_out), 32'd1);
        idleCycles(2);
        applyStimulus(0, 0, 1, 0, 0, 32'd0, 1, 1, 1, 8'd0);
        idleCycles(1);
        checkValue("irq_cleared", 32'(bus.irq_out), 32'd0);

        $display("[TB] down wrap");
        applyStimulus(0, 1, 1, 0, 0, 32'd1, 1, 0, 1, 8'd0);
        idleCycles(2);
        checkValue("count_down_wrap", bus.count_out, 32'hFFFF_FFFF);
        idleCycles(3);

        $display("[TB] load on the wrap edge");
        applyStimulus(0, 1, 1, 0, 0, 32'hFFFF_FFFF, 1, 1, 1, 8'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd5, 0, 0, 0, 8'd0);
        idleCycles(3);
        checkValue("irq_no_wrap", 32'(bus.irq_out), 32'd0);

        $display("[TB] basic FIFO");
        applyStimulus(0, 0, 1, 0, 0, 32'd0, 0, 1, 0, 8'd0);
        applyStimulus(0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 8'hA1);
        applyStimulus(0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 8'hB2);
        checkValue("fifo_head_a1", 32'(bus.fifo_data_out), 32'hA1);
        applyStimulus(0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 8'd0);
        checkValue("fifo_head_b2", 32'(bus.fifo_data_out), 32'hB2);
        applyStimulus(0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 8'd0);
        applyStimulus(0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 8'd0);
        checkValue("fifo_count_empty", 32'(bus.fifo_word_count), 32'd0);

        $display("[TB] FIFO fill, drop while full, push+pop while full");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 8'($urandom_range(0, 254)));
        end
        applyStimulus(0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 8'hFF);
        checkValue("fifo_full_count", 32'(bus.fifo_word_count), 32'd16);
        applyStimulus(0, 0, 0, 1, 1, 32'd0, 0, 0, 0, 8'h5C);
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 8'd0);
        end
        applyStimulus(0, 0, 0, 1, 1, 32'd0, 0, 0, 0, 8'h3C);
        checkValue("fifo_push_pop_empty", 32'(bus.fifo_word_count), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 8'd0);

        $display("[TB] reset mid-count with FIFO occupied");
        applyStimulus(0, 1, 1, 0, 0, 32'd200, 1, 1, 1, 8'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 32'd0, 0, 0, 0, 8'(8'h10 + i));
        end
        applyStimulus(1, 1, 1, 1, 0, 32'd77, 1, 0, 1, 8'h99);
        checkValue("reset_count_const", bus.count_out, 32'd0);
        checkValue("reset_en_const", 32'(bus.en_out), 32'd0);
        checkValue("reset_empty_const", 32'(bus.fifo_empty), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rnd_cin = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                1:       rnd_cin = 32'($urandom_range(0, 3));
                2:       rnd_cin = 32'd995 + 32'($urandom_range(0, 10));
                default: rnd_cin = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 99) < 2),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 2) != 0),
                          (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
                          rnd_cin,
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
